axi_ram_init_ctrl: RTL and testbench

AXI4 write-only sequencer that fills the SweRVolf main RAM with a fixed pattern after reset, before the core is allowed to use it. It sits between the RAM controller and the interconnect's RAM port and generates the RAM init-done and init-error status. swervolf_core already consumes these as `i_ram_init_done` and `i_ram_init_error`. The top level uses `o_init_done` to select the core write channels instead of this block's write channels. Read channels are not touched.

---
 rtl/axi_ram_init_ctrl.sv | 115 +++++++++++
 tb/tb_axi_ram_init_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_init_ctrl.sv
// AXI4 write-only sequencer that fills the main RAM with a constant pattern after reset.
// Drives init-done/init-error status so the top level can hand the write channels to the core.
module axi_ram_init_ctrl #(
    parameter int          ID_WIDTH  = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MEM_SIZE  = 32'h10000,
    parameter int          BURST_LEN = 16,
    parameter logic [63:0] FILL      = 64'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_busy,
    output logic                o_init_done,
    output logic                o_init_error
);

    localparam int unsigned    NUM_BURSTS  = MEM_SIZE / (BURST_LEN * 8);
    localparam int             BCW         = $clog2(NUM_BURSTS) + 1;
    localparam logic [BCW-1:0] LAST_BURST  = BCW'(NUM_BURSTS - 1);
    localparam logic [31:0]    BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [7:0]     LAST_BEAT   = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     beat_cnt;
    logic [BCW-1:0] burst_cnt;
    logic           err_q;
    logic           b_bad;

    assign b_bad = (i_bresp != 2'b00) || (i_bid != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_ADDR;
            S_ADDR: if (i_awready) state_nxt = S_DATA;
            S_DATA: if (i_wready && beat_cnt == LAST_BEAT) state_nxt = S_RESP;
            // A bad response abandons the rest of the fill.
            S_RESP: if (i_bvalid) state_nxt = (b_bad || burst_cnt == LAST_BURST) ? S_DONE : S_ADDR;
            S_DONE: if (i_start) state_nxt = S_ADDR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_awaddr  <= BASE_ADDR;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                S_ADDR: if (i_awready) beat_cnt <= '0;
                S_DATA: if (i_wready) beat_cnt <= beat_cnt + 8'd1;
                S_RESP: begin
                    if (i_bvalid) begin
                        if (b_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            // May wrap past 2^32 on the final burst; that address is never issued.
                            o_awaddr  <= o_awaddr + BURST_BYTES;
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_start) begin
                        o_awaddr  <= BASE_ADDR;
                        burst_cnt <= '0;
                        err_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_awid       = '0;
    assign o_awlen      = LAST_BEAT;
    assign o_awsize     = 3'd3;
    assign o_awburst    = 2'b01;
    assign o_wdata      = FILL;
    assign o_wstrb      = 8'hff;
    assign o_awvalid    = (state == S_ADDR);
    assign o_wvalid     = (state == S_DATA);
    assign o_wlast      = (state == S_DATA) && (beat_cnt == LAST_BEAT);
    assign o_bready     = (state == S_RESP);
    assign o_busy       = (state == S_ADDR) || (state == S_DATA) || (state == S_RESP);
    assign o_init_done  = (state == S_DONE);
    assign o_init_error = err_q;

endmodule

// File: tb/tb_axi_ram_init_ctrl.sv
// Bench for axi_ram_init_ctrl: randomized AXI slave, transaction-level model checked every cycle,
// plus a second single-beat instance for the minimum-size boundary.
module tb_axi_ram_init_ctrl;

    localparam int          IDW   = 6;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam logic [31:0] MSZ   = 32'd256;
    localparam int          BL    = 4;
    localparam logic [63:0] FILLV = 64'hDEADBEEF_CAFEF00D;
    localparam int          NB    = 8;
    localparam int          NW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // main instance
    logic            rst = 1'b1, i_start = 1'b0;
    logic [IDW-1:0]  o_awid, i_bid = '0;
    logic [31:0]     o_awaddr;
    logic [7:0]      o_awlen, o_wstrb;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst, i_bresp = '0;
    logic            o_awvalid, i_awready = 1'b0, o_wlast, o_wvalid, i_wready = 1'b0;
    logic            i_bvalid = 1'b0, o_bready, o_busy, o_init_done, o_init_error;
    logic [63:0]     o_wdata;

    axi_ram_init_ctrl #(.ID_WIDTH(IDW), .BASE_ADDR(BASE), .MEM_SIZE(MSZ), .BURST_LEN(BL), .FILL(FILLV)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_busy(o_busy), .o_init_done(o_init_done), .o_init_error(o_init_error)
    );

    // single-beat instance
    logic            rst_s = 1'b1, bvalid_s;
    logic [IDW-1:0]  awid_s;
    logic [31:0]     awaddr_s;
    logic [7:0]      awlen_s, wstrb_s;
    logic [2:0]      awsize_s;
    logic [1:0]      awburst_s;
    logic            awvalid_s, wlast_s, wvalid_s, bready_s, busy_s, done_s, error_s;
    logic [63:0]     wdata_s;
    int              awcnt_s;
    bit              s_fin = 1'b0;

    axi_ram_init_ctrl #(.ID_WIDTH(IDW), .BASE_ADDR(32'h0), .MEM_SIZE(32'd8), .BURST_LEN(1), .FILL(64'h0)) dut_s (
        .clk(clk), .rst(rst_s), .i_start(1'b0),
        .o_awid(awid_s), .o_awaddr(awaddr_s), .o_awlen(awlen_s), .o_awsize(awsize_s),
        .o_awburst(awburst_s), .o_awvalid(awvalid_s), .i_awready(1'b1),
        .o_wdata(wdata_s), .o_wstrb(wstrb_s), .o_wlast(wlast_s), .o_wvalid(wvalid_s), .i_wready(1'b1),
        .i_bid('0), .i_bresp(2'b00), .i_bvalid(bvalid_s), .o_bready(bready_s),
        .o_busy(busy_s), .o_init_done(done_s), .o_init_error(error_s)
    );

    always @(posedge clk) begin
        if (rst_s) begin
            bvalid_s <= 1'b0;
            awcnt_s  <= 0;
        end else begin
            if (awvalid_s) awcnt_s <= awcnt_s + 1;
            if (wvalid_s && wlast_s) bvalid_s <= 1'b1;
            else if (bready_s)       bvalid_s <= 1'b0;
        end
    end

    // Model: phase 0 = just reset, 1 = filling, 2 = finished, 3 = before first reset.
    // Within a fill, sub 0 = address, 1 = data beats, 2 = awaiting response.
    int          phase = 3, sub = 0, k = 0, beat = 0, aw_cnt = 0, b_dly = 0;
    int          err_burst = -1;
    bit          err_bid = 1'b0, stall = 1'b0, b_pend = 1'b0, exp_err = 1'b0;
    logic [63:0] mem [NW];

    always @(negedge clk) begin
        bit aw_hs, w_hs, b_hs;
        if (phase != 3) begin
            chk("awvalid", o_awvalid, phase == 1 && sub == 0);
            chk("wvalid",  o_wvalid,  phase == 1 && sub == 1);
            chk("wlast",   o_wlast,   phase == 1 && sub == 1 && beat == BL - 1);
            chk("bready",  o_bready,  phase == 1 && sub == 2);
            chk("busy",    o_busy,    phase == 1);
            chk("done",    o_init_done, phase == 2);
            chk("error",   o_init_error, exp_err);
            chk("awaddr",  o_awaddr, 32'(BASE + 32'(k * BL * 8)));
            if (o_awvalid) begin
                chk("awlen", o_awlen, BL - 1);
                chk("awsize_burst_id", {o_awsize, o_awburst, o_awid}, {3'd3, 2'b01, 6'd0});
            end
            if (o_wvalid) chk("wdata_strb", {o_wdata[55:0], o_wstrb}, {FILLV[55:0], 8'hff});
        end
        i_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        i_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        i_bvalid  = b_pend && b_dly == 0;
        if (b_pend && b_dly != 0) b_dly--;
        if (!i_bvalid) begin
            i_bresp = 2'($urandom);
            i_bid   = 6'($urandom);
        end else if (k == err_burst) begin
            i_bresp = err_bid ? 2'b00 : 2'b10;
            i_bid   = err_bid ? 6'd5 : 6'd0;
        end else begin
            i_bresp = 2'b00;
            i_bid   = '0;
        end
        aw_hs = o_awvalid && i_awready;
        w_hs  = o_wvalid && i_wready;
        b_hs  = i_bvalid && o_bready;
        if (rst) begin
            phase = 0; sub = 0; k = 0; beat = 0; aw_cnt = 0; b_pend = 0; exp_err = 0;
        end else begin
            if (aw_hs) aw_cnt++;
            case (phase)
                0: begin phase = 1; sub = 0; k = 0; end
                1: case (sub)
                    0: if (aw_hs) begin sub = 1; beat = 0; end
                    1: if (w_hs) begin
                        if (k * BL + beat < NW) mem[k * BL + beat] = o_wdata;
                        if (beat == BL - 1) begin
                            sub = 2; b_pend = 1;
                            b_dly = stall ? $urandom_range(0, 2) : 0;
                        end else beat++;
                    end
                    default: if (b_hs) begin
                        b_pend = 0;
                        if (i_bresp != 2'b00 || i_bid != '0) begin
                            exp_err = 1; phase = 2;
                        end else begin
                            k++;
                            if (k == NB) phase = 2;
                            else sub = 0;
                        end
                    end
                endcase
                2: if (i_start) begin phase = 1; sub = 0; k = 0; exp_err = 0; aw_cnt = 0; end
                default: ;
            endcase
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < NW; i++) mem[i] = 64'h0;
    endtask

    task automatic chk_mem(input string name);
        int n = 0;
        for (int i = 0; i < NW; i++) if (mem[i] === FILLV) n++;
        chk(name, n, NW);
    endtask

    // Counts edges from the one that samples the release/start until done is visible.
    task automatic run_to_done(input bit rand_start, output int cyc);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); cyc++;
            #1;
            if (o_init_done) break;
            #1;
            i_start = (rand_start && cyc < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        i_start = 1'b0;
        chk("done_reached", o_init_done, 1'b1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2; i_start = 1'b1;
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2; rst_s = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk); cyc++;
            #1;
            if (wvalid_s) chk("s_wlast", wlast_s, 1'b1);
            if (awvalid_s) chk("s_awlen", awlen_s, 8'd0);
            if (done_s) break;
        end
        chk("s_latency", cyc, 4);
        chk("s_awcount", awcnt_s, 1);
        chk("s_error", error_s, 1'b0);
        s_fin = 1'b1;
    end

    initial begin
        int cyc;
        #500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", o_awvalid, 1'b0);
        chk("rst_awaddr", o_awaddr, BASE);
        chk("rst_flags", {o_busy, o_init_done, o_init_error}, 3'b000);

        // clean fill, always-ready slave
        #1; rst = 1'b0;
        run_to_done(1'b0, cyc);
        chk("clean_latency", cyc, 49);
        chk("clean_bursts", aw_cnt, NB);
        chk("clean_error", o_init_error, 1'b0);
        chk("clean_final_addr", o_awaddr, 32'h0);
        chk_mem("clean_mem");

        // restart with random stalls
        stall = 1'b1; clear_mem();
        pulse_start();
        @(posedge clk); #1;
        chk("start_done_fall", o_init_done, 1'b0);
        chk("start_awvalid", o_awvalid, 1'b1);
        chk("start_awaddr", o_awaddr, BASE);
        #1; i_start = 1'b0;
        run_to_done(1'b0, cyc);
        chk("stall_bursts", aw_cnt, NB);
        chk("stall_error", o_init_error, 1'b0);
        chk_mem("stall_mem");

        // bresp error on third burst
        stall = 1'b0; err_burst = 2; err_bid = 1'b0;
        pulse_start();
        run_to_done(1'b0, cyc);
        chk("bresp_err_flag", o_init_error, 1'b1);
        chk("bresp_err_bursts", aw_cnt, 3);
        chk("bresp_err_latency", cyc, 1 + 3 * (BL + 2));
        err_burst = -1; clear_mem();
        pulse_start();
        run_to_done(1'b0, cyc);
        chk("recover_error", o_init_error, 1'b0);
        chk("recover_bursts", aw_cnt, NB);
        chk_mem("recover_mem");

        // wrong bid on first burst, stalled slave
        stall = 1'b1; err_burst = 0; err_bid = 1'b1;
        pulse_start();
        run_to_done(1'b0, cyc);
        chk("bid_err_flag", o_init_error, 1'b1);
        chk("bid_err_bursts", aw_cnt, 1);
        err_burst = -1;

        // reset in the middle of a data phase
        clear_mem();
        pulse_start();
        @(posedge clk); #2; i_start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (phase == 1 && sub == 1 && k == 2 && beat == 2) break;
            @(posedge clk); #2;
        end
        chk("mid_data_reached", {phase == 1, sub == 1, k == 2, beat == 2}, 4'hf);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valids", {o_awvalid, o_wvalid, o_wlast, o_bready}, 4'h0);
        chk("abort_flags", {o_busy, o_init_done, o_init_error}, 3'b000);
        chk("abort_awaddr", o_awaddr, BASE);
        #1; rst = 1'b0;
        run_to_done(1'b0, cyc);
        chk("abort_bursts", aw_cnt, NB);
        chk_mem("abort_mem");

        // start pulses while busy must be ignored
        stall = 1'b0;
        pulse_start();
        run_to_done(1'b1, cyc);
        chk("ignore_latency", cyc, 49);
        chk("ignore_bursts", aw_cnt, NB);

        for (int i = 0; i < 100 && !s_fin; i++) @(posedge clk);
        chk("single_beat_finished", s_fin, 1'b1);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
